// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, load_op bit indices and field offsets
// for the execute->memory, memory->writeback and memory->execute buses.
package cpu_pkg;

  localparam int ES_TO_MS_BUS_W = 175;
  localparam int MS_TO_WS_BUS_W = 166;
  localparam int MS_TO_ES_BUS_W = 38;

  localparam int CSR_BUS_W  = 64;
  localparam int LOAD_OP_W  = 6;
  localparam int STORE_OP_W = 3;

  // load_op is one-hot; ll.w behaves as ld.w in this stage
  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;
  localparam int LL_W  = 5;

  localparam int ES_CSR_LSB      = 111;
  localparam int ES_LOAD_OP_LSB  = 105;
  localparam int ES_STORE_OP_LSB = 102;
  localparam int ES_REG_WE       = 101;
  localparam int ES_DEST_LSB     = 96;
  localparam int ES_RESULT_LSB   = 64;
  localparam int ES_PC_LSB       = 32;
  localparam int ES_INST_LSB     = 0;

  localparam int WS_CSR_LSB    = 102;
  localparam int WS_REG_WE     = 101;
  localparam int WS_DEST_LSB   = 96;
  localparam int WS_RESULT_LSB = 64;
  localparam int WS_PC_LSB     = 32;
  localparam int WS_INST_LSB   = 0;

  localparam int FWD_REG_WE     = 37;
  localparam int FWD_DEST_LSB   = 32;
  localparam int FWD_RESULT_LSB = 0;

  typedef enum logic {
    BUF_LIVE = 1'b0,
    BUF_HELD = 1'b1
  } buf_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword from a 32-bit
// SRAM word and sign- or zero-extends it according to the one-hot load_op.
module load_align
  import cpu_pkg::*;
(
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr,
  input  logic [31:0]          raw_data,
  output logic [31:0]          load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_data[8*addr +: 8];
    // halfword alignment ignores addr[0]
    half_sel = addr[1] ? raw_data[31:16] : raw_data[15:0];

    load_data = raw_data;
    if (load_op[LD_B]) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (load_op[LD_BU]) begin
      load_data = {24'b0, byte_sel};
    end else if (load_op[LD_H]) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (load_op[LD_HU]) begin
      load_data = {16'b0, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, buffers SRAM read
// data across stalls, aligns load data. Optional macro MS_LOAD_FWD_EN lets
// load results forward to execute in the memory cycle.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = 175,
  parameter int MS_TO_WS_BUS_WD = 166,
  parameter int MS_TO_ES_BUS_WD = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
  output logic                       ms_is_load
);

  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_q, es_to_ms_bus_d;
  buf_state_e                 buf_state_q, buf_state_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;

  logic                 reg_hold;
  logic [CSR_BUS_W-1:0] csr_bus;
  logic [LOAD_OP_W-1:0] load_op;
  logic                 reg_we;
  logic [4:0]           dest;
  logic [31:0]          es_result;
  logic [31:0]          pc;
  logic [31:0]          inst;
  logic                 is_load;
  logic [31:0]          raw_data;
  logic [31:0]          load_data;
  logic [31:0]          ms_result;
  logic                 fwd_we;
  logic                 unused_bits;

  assign csr_bus   = es_to_ms_bus_q[ES_CSR_LSB +: CSR_BUS_W];
  assign load_op   = es_to_ms_bus_q[ES_LOAD_OP_LSB +: LOAD_OP_W];
  assign reg_we    = es_to_ms_bus_q[ES_REG_WE];
  assign dest      = es_to_ms_bus_q[ES_DEST_LSB +: 5];
  assign es_result = es_to_ms_bus_q[ES_RESULT_LSB +: 32];
  assign pc        = es_to_ms_bus_q[ES_PC_LSB +: 32];
  assign inst      = es_to_ms_bus_q[ES_INST_LSB +: 32];
  assign is_load   = |load_op;

  // store_op ends here; only execute/memory stall bits matter to this stage
  assign unused_bits = ^{es_to_ms_bus_q[ES_STORE_OP_LSB +: STORE_OP_W],
                         stall[5], stall[2:0]};

  // Contents survive the edge only when both execute and memory are stalled
  assign reg_hold = ~flush & stall[3] & stall[4];

  always_comb begin
    es_to_ms_bus_d = es_to_ms_bus_q;
    if (flush) begin
      es_to_ms_bus_d = '0;
    end else if (stall[3] && !stall[4]) begin
      es_to_ms_bus_d = '0;
    end else if (!stall[3]) begin
      es_to_ms_bus_d = es_to_ms_bus;
    end
  end

  // SRAM data is only valid one cycle after the request; keep it while stalled
  always_comb begin
    buf_state_d = buf_state_q;
    rdata_buf_d = rdata_buf_q;
    case (buf_state_q)
      BUF_LIVE: begin
        if (reg_hold && is_load) begin
          buf_state_d = BUF_HELD;
          rdata_buf_d = data_sram_rdata;
        end
      end
      BUF_HELD: begin
        if (!reg_hold) begin
          buf_state_d = BUF_LIVE;
        end
      end
      default: buf_state_d = BUF_LIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_to_ms_bus_q <= '0;
      buf_state_q    <= BUF_LIVE;
    end else begin
      es_to_ms_bus_q <= es_to_ms_bus_d;
      buf_state_q    <= buf_state_d;
    end
  end

  always_ff @(posedge clk) begin
    rdata_buf_q <= rdata_buf_d;
  end

  assign raw_data = (buf_state_q == BUF_HELD) ? rdata_buf_q : data_sram_rdata;

  load_align u_load_align (
    .load_op   (load_op),
    .addr      (es_result[1:0]),
    .raw_data  (raw_data),
    .load_data (load_data)
  );

  assign ms_result = is_load ? load_data : es_result;

`ifdef MS_LOAD_FWD_EN
  assign fwd_we = reg_we;
`else
  // decode stalls on ms_is_load, so loads must not produce a forwarding hit
  assign fwd_we = reg_we & ~is_load;
`endif

  assign ms_to_ws_bus = {csr_bus, reg_we, dest, ms_result, pc, inst};
  assign ms_to_es_bus = {fwd_we, dest, ms_result};
  assign ms_is_load   = is_load;

endmodule
